// File: rtl/sprite_rom_fetcher.sv
// Avalon-MM read master fetching one sprite row from a 16-bit ROM into an 8-bit pixel stream.
// Optional horizontal mirroring is compiled in with SPRITE_FETCH_MIRROR_EN.
module sprite_rom_fetcher #(
  parameter int ADDR_W        = 7,
  parameter int WORDS_PER_ROW = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     req_valid,
  output logic                                     req_ready,
  input  logic [ADDR_W-$clog2(WORDS_PER_ROW)-1:0]  req_row,
  input  logic                                     req_hflip,
  output logic [ADDR_W-1:0]                        rom_address,
  output logic                                     rom_chipselect,
  output logic                                     rom_write,
  output logic [1:0]                               rom_byteenable,
  output logic                                     rom_clken,
  input  logic [15:0]                              rom_readdata,
  output logic                                     pix_valid,
  input  logic                                     pix_ready,
  output logic [7:0]                               pix_data,
  output logic                                     pix_last,
  output logic                                     busy
);
  localparam int CNT_W = $clog2(WORDS_PER_ROW);
  localparam int ROW_W = ADDR_W - CNT_W;
  localparam int PIX_W = CNT_W + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state, state_nxt;

  logic [ROW_W-1:0] row_q;
  logic [CNT_W-1:0] issue_cnt, word_idx;
  logic [PIX_W-1:0] pix_cnt;
  logic             inflight;
  logic [15:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   fifo_count, credit_sum;
  logic [15:0]      upk_word;
  logic             upk_full, upk_sel;
  logic             mirror, accept, issue, credit, fifo_push, fifo_pop, pix_hs;

`ifdef SPRITE_FETCH_MIRROR_EN
  logic hflip_q;
  always_ff @(posedge clk) begin
    if (reset)       hflip_q <= 1'b0;
    else if (accept) hflip_q <= req_hflip;
  end
  assign mirror = hflip_q;
`else
  logic unused_hflip;
  assign unused_hflip = req_hflip;
  assign mirror       = 1'b0;
`endif

  assign rom_write      = 1'b0;
  assign rom_byteenable = 2'b11;
  assign rom_clken      = 1'b1;

  // Credit counts the read still in flight so a returning word always has a slot.
  assign credit_sum = fifo_count + {{PTR_W{1'b0}}, inflight};
  assign credit     = credit_sum < (PTR_W+1)'(FIFO_DEPTH);
  assign accept     = req_ready && req_valid;
  assign pix_hs     = upk_full && pix_ready;

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    busy      = 1'b1;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        req_ready = !reset;
        if (req_valid && !reset) state_nxt = FETCH;
      end
      FETCH: begin
        issue = credit;
        if (credit && issue_cnt == CNT_W'(WORDS_PER_ROW-1)) state_nxt = DRAIN;
      end
      DRAIN: if (pix_hs && pix_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q     <= '0;
      issue_cnt <= '0;
      pix_cnt   <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      if (accept) begin
        row_q     <= req_row;
        issue_cnt <= '0;
        pix_cnt   <= '0;
      end else begin
        if (issue)  issue_cnt <= issue_cnt + 1'b1;
        if (pix_hs) pix_cnt   <= pix_cnt + 1'b1;
      end
    end
  end

  assign word_idx       = mirror ? ~issue_cnt : issue_cnt;
  assign rom_chipselect = issue;
  assign rom_address    = issue ? {row_q, word_idx} : '0;

  // Read data lands one cycle after its address cycle.
  assign fifo_push = inflight;
  assign fifo_pop  = (fifo_count != '0) && (!upk_full || (upk_sel && pix_hs));

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= rom_readdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + {{PTR_W{1'b0}}, fifo_push} - {{PTR_W{1'b0}}, fifo_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      upk_word <= '0;
      upk_full <= 1'b0;
      upk_sel  <= 1'b0;
    end else if (fifo_pop) begin
      upk_word <= fifo_mem[rd_ptr];
      upk_full <= 1'b1;
      upk_sel  <= 1'b0;
    end else if (pix_hs) begin
      if (!upk_sel) upk_sel  <= 1'b1;
      else          upk_full <= 1'b0;
    end
  end

  // Mirrored rows emit the low byte of each word first.
  assign pix_valid = upk_full;
  assign pix_data  = (upk_sel ^ mirror) ? upk_word[7:0] : upk_word[15:8];
  assign pix_last  = upk_full && (pix_cnt == PIX_W'(2*WORDS_PER_ROW-1));

endmodule

// File: tb/tb_sprite_rom_fetcher.sv
// Randomized bench for sprite_rom_fetcher against a per-pixel model of the row layout.
module tb_sprite_rom_fetcher;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_hflip = 1'b0;
  logic [3:0]  req_row = '0;
  logic [6:0]  rom_address;
  logic        rom_chipselect, rom_write, rom_clken;
  logic [1:0]  rom_byteenable;
  logic [15:0] rom_readdata = '0;
  logic        pix_valid, pix_ready = 1'b0, pix_last, busy;
  logic [7:0]  pix_data;

  logic [15:0] rom_mem [128];
  int checks = 0, errors = 0, cyc = 0;
  int last_hs_cyc = 0;

  sprite_rom_fetcher dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_row(req_row), .req_hflip(req_hflip), .rom_address(rom_address),
    .rom_chipselect(rom_chipselect), .rom_write(rom_write),
    .rom_byteenable(rom_byteenable), .rom_clken(rom_clken),
    .rom_readdata(rom_readdata), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_last(pix_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) rom_readdata <= rom_mem[rom_address];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit eff_mirror(input bit hflip);
`ifdef SPRITE_FETCH_MIRROR_EN
    return hflip;
`else
    return 1'b0;
`endif
  endfunction

  // Pixel i of a row: mirrored rows read pixel 15-i of the plain row.
  function automatic logic [7:0] exp_pix(input int row, input bit mir, input int i);
    int p;
    logic [15:0] w;
    p = mir ? 15 - i : i;
    w = rom_mem[row*8 + p/2];
    return (p % 2 == 0) ? w[15:8] : w[7:0];
  endfunction

  // Fetch one row; abort_at >= 0 asserts reset once that many pixels have been accepted.
  task automatic run_row(input int row, input bit hflip, input int duty,
                         input bit keep_valid, input bit chk_b2b, input int abort_at);
    int t, idx, issued, acc_cyc, max_buf;
    bit mir, first, done;
    mir = eff_mirror(hflip);
    @(negedge clk);
    req_row = 4'(row); req_hflip = hflip; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 100) begin @(negedge clk); t++; end
    if (!req_ready) begin chk("req_timeout", 0, 1); req_valid = 1'b0; return; end
    acc_cyc = cyc + 1;
    if (chk_b2b) chk("b2b_accept_gap", acc_cyc - last_hs_cyc, 1);
    @(posedge clk);
    idx = 0; issued = 0; max_buf = 0; first = 1'b1; done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (keep_valid) begin req_row = 4'($urandom); req_hflip = 1'($urandom); end
      else req_valid = 1'b0;
      if (abort_at >= 0 && idx == abort_at) begin reset = 1'b1; return; end
      if (rom_chipselect) begin
        chk("addr", rom_address, mir ? row*8 + 7 - issued : row*8 + issued);
        issued++;
      end
      if (issued - idx/2 > max_buf) max_buf = issued - idx/2;
      pix_ready = ($urandom_range(99) < duty);
      if (pix_valid) begin
        if (first && duty >= 100) chk("latency", cyc - acc_cyc, 3);
        first = 1'b0;
        chk("pix_data", pix_data, exp_pix(row, mir, idx));
        chk("pix_last", pix_last, idx == 15);
        if (pix_ready) begin
          idx++;
          if (idx == 16) begin done = 1'b1; last_hs_cyc = cyc + 1; end
        end
      end
    end
    chk("row_pixels", idx, 16);
    chk("row_words", issued, 8);
    chk("buffered_le_5", max_buf <= 5, 1);
    if (!keep_valid) begin
      @(negedge clk);
      chk("ready_return", req_ready, 1);
      chk("idle_no_valid", pix_valid, 0);
    end
  endtask

  initial begin
    for (int a = 0; a < 128; a++) rom_mem[a] = {4'(a/8), 4'(a%8), 8'hA5 ^ 8'(a%8)};
    repeat (3) @(negedge clk);
    chk("rst_cs", rom_chipselect, 0);
    chk("rst_addr", rom_address, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_last", pix_last, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", req_ready, 1);
    chk("const_outs", {rom_write, rom_byteenable, rom_clken}, 4'b0111);

    run_row(3, 0, 100, 0, 0, -1);
    run_row(15, 0, 100, 0, 0, -1);
    run_row(3, 1, 100, 0, 0, -1);
    run_row(0, 1'($urandom), 30, 0, 0, -1);

    // Request held high across two rows; busy-time row/hflip noise must not be captured.
    run_row(5, 0, 100, 1, 0, -1);
    run_row(9, 0, 100, 1, 1, -1);
    req_valid = 1'b0;
    @(negedge clk);

    // Reset mid-row after five pixels.
    run_row(2, 0, 100, 0, 0, 5);
    @(negedge clk);
    chk("midrst_ready", req_ready, 0);
    chk("midrst_busy", busy, 0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", pix_valid, 0);
      if (i == 0) chk("post_rst_ready", req_ready, 1);
    end
    run_row(0, 0, 100, 0, 0, -1);

    for (int r = 0; r < 6; r++)
      run_row($urandom_range(15), 1'($urandom), $urandom_range(20, 100), 0, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sprite_rom_fetcher.md
# sprite_rom_fetcher

Avalon-MM read master that fetches one sprite row at a time from a 128 x 16-bit single-port sprite ROM slave and emits it as an 8-bit-per-pixel valid/ready stream toward the display compositor. Each 16-bit ROM word holds two pixels; a 16x16 sprite occupies 16 rows of 8 words. The block sits between the sprite-engine row scheduler and the on-chip sprite memory, absorbing the memory's one-cycle read latency and downstream backpressure with a small word FIFO.

## Interface
- ADDR_W, 7, ROM word-address width
- WORDS_PER_ROW, 8, ROM words per sprite row; power of two
- FIFO_DEPTH, 4, word FIFO entries; power of two, at least 2

Ports:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  row request strobe
- req_ready  out  1  block idle and able to accept a request
- req_row  in  ADDR_W-log2(WORDS_PER_ROW), 4 by default  row index
- req_hflip  in  1  horizontal mirror request; used only with SPRITE_FETCH_MIRROR_EN
- rom_address  out  ADDR_W  ROM word address
- rom_chipselect  out  1  read strobe, one word per high cycle
- rom_write  out  1  constant 0
- rom_byteenable  out  2  constant 2'b11
- rom_clken  out  1  constant 1
- rom_readdata  in  16  ROM data; valid in the cycle after the address cycle
- pix_valid  out  1  pixel available
- pix_ready  in  1  downstream accepts pixel
- pix_data  out  8  pixel value
- pix_last  out  1  final pixel of the row; qualified by pix_valid
- busy  out  1  not IDLE

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE: req_ready=1. On req_valid, capture row and hflip, clear issue count, clear pixel count, and go to FETCH. busy=0.
- FETCH: issue one read per cycle when issue_cnt < WORDS_PER_ROW and fifo_count + inflight < FIFO_DEPTH.
  - Address is row*WORDS_PER_ROW + k for k = issue_cnt, or WORDS_PER_ROW-1-k when mirrored.
  - When the last word issues, go to DRAIN.
- Capture: a read issued in cycle N writes rom_readdata into the FIFO at the end of cycle N+1. inflight is 0 or 1.
- Unpacker: holds one word and a byte select.
  - Output order: pix_data = word[15:8] first, then word[7:0]. Mirrored order is [7:0] first, then [15:8].
  - It pops the next FIFO word when its second byte is accepted, or when it is empty.
- pix_last=1 on pixel 2*WORDS_PER_ROW-1 of the row.
- DRAIN → IDLE on the pix_last handshake. req_ready rises in the following cycle.
- req_valid while busy: ignored, because req_ready=0. No queuing.
- FIFO never overflows, because the credit check includes the in-flight read. An empty FIFO with an empty unpacker gives pix_valid=0.
- pix_valid stays high until accepted. pix_data and pix_last are stable while pix_valid=1 and pix_ready=0.
- Reset mid-row: state returns to IDLE and FIFO, counters, unpacker and inflight are cleared. A read returning in the cycle after reset is discarded. No partial row is emitted after reset.

## Timing
- Reset values: rom_chipselect=0, rom_address=0, pix_valid=0, pix_last=0, pix_data=0, busy=0, req_ready=0. req_ready=1 in the first cycle with reset low.
- Request accepted at edge E0:
  - first rom_chipselect in the cycle after E0;
  - first word enters the FIFO at E2;
  - pix_valid rises after E3, giving a latency of 3 cycles.
- With pix_ready held high, throughput is 1 pixel/cycle. The 16 pixels appear in consecutive cycles after E3..E18, and req_ready=1 after E19.
- Back-to-back rows: the next request can be accepted in the cycle req_ready returns high. Dead time between rows is 4 cycles.
- pix_ready low: reads stall once the FIFO credit is exhausted. No word is lost or duplicated.

## Configuration
- SPRITE_FETCH_MIRROR_EN:
  - Defined: req_hflip=1 reverses the word order and the byte order within each word, so pixel i of the row maps to pixel 15-i.
  - Undefined: req_hflip is ignored and the unmirrored order is always used; the mirror logic is not synthesized.

## Test plan
- Reset mid-row at pixel 5 → no further pix_valid; req_ready=1 one cycle after reset falls; a new request on row 0 yields the correct 16 pixels.
- ROM word at address 8k+j = {k,j,byte 0xA5 ^ j}; request row 3 with pix_ready=1 → pix_valid rises 3 cycles after acceptance; pixels 0x30,0xA5,0x31,0xA4,…; pix_last on the 16th pixel; addresses 0x18..0x1F issued in order.
- Row 15 (addresses 0x78..0x7F, top of ROM) → all 8 words fetched, no address wrap to 0.
- pix_ready toggled pseudo-randomly at 30% duty → exact 16-pixel sequence, with outputs held stable during stalls and at most FIFO_DEPTH+1 words buffered.
- req_valid held high continuously across two rows → second row accepted exactly on the req_ready rise; req_valid during busy is not captured.
- With SPRITE_FETCH_MIRROR_EN and hflip=1 on row 3 → addresses 0x1F..0x18; pixel order is the exact reverse of the unmirrored case. Without the macro, hflip=1 gives the unmirrored order.
